cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.

---
 rtl/cla_pipe_adder_if.sv | 38 +++
 rtl/cla_pipe_adder.sv | 136 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if: valid/ready operand and result bundle for cla_pipe_adder.
//   in_valid/in_ready  operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready result beat handshake (sum, cout, ovf)
//   ovf exists only when CLA_OVERFLOW_EN is defined.
// Modports: master = operand producer / result consumer, slave = adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef CLA_OVERFLOW_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef CLA_OVERFLOW_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
//   Each pipeline stage adds 4*GPS bits using GPS 4-bit lookahead groups
//   (carry ripples group to group inside a stage); the stage carry-out is
//   registered. Latency = STAGES = WIDTH/(4*GPS) cycles, 1 beat/cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cla_pipe_adder_if.slave: in_valid/in_ready, a, b, cin, sub,
//        out_valid/out_ready, sum, cout, ovf (ovf only with CLA_OVERFLOW_EN)
// Optional feature macro: CLA_OVERFLOW_EN (signed overflow output).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  cla_pipe_adder_if.slave  bus
);
  localparam int unsigned SW     = 4 * GPS;
  localparam int unsigned STAGES = WIDTH / SW;

  // Full lookahead 4-bit group: returns {c4, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g, p;
    logic c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  // One stage slice: GPS groups, carry rippling between groups. Returns {cout, sum}.
  function automatic logic [SW:0] stage_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW:0] r;
    logic [4:0]  g4;
    logic        c;
    r = '0;
    c = ci;
    for (int unsigned i = 0; i < GPS; i++) begin
      g4         = cla4(x[4*i +: 4], y[4*i +: 4], c);
      r[4*i +: 4] = g4[3:0];
      c          = g4[4];
    end
    r[SW] = c;
    return r;
  endfunction

  // Per-stage state. Operands are shifted right each stage so the slice a
  // stage works on is always in the low SW bits; result bits accumulate in
  // place (skew registers) as the beat moves up the pipe.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             v_d [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
`ifdef CLA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif
  logic             advance;

  assign advance = !v_q[STAGES-1] || bus.out_ready;

  always_comb begin
    logic [WIDTH-1:0] ai, bi;
    logic [SW:0]      r;
    // Stage 0 slices straight from the inputs; subtract is a + ~b + 1.
    ai     = bus.a;
    bi     = bus.sub ? ~bus.b : bus.b;
    r      = stage_add(ai[SW-1:0], bi[SW-1:0], bus.sub | bus.cin);
    v_d[0] = bus.in_valid;
    c_d[0] = r[SW];
    a_d[0] = ai >> SW;
    b_d[0] = bi >> SW;
    s_d[0] = WIDTH'(r[SW-1:0]);
    for (int unsigned k = 1; k < STAGES; k++) begin
      ai     = a_q[k-1];
      bi     = b_q[k-1];
      r      = stage_add(ai[SW-1:0], bi[SW-1:0], c_q[k-1]);
      v_d[k] = v_q[k-1];
      c_d[k] = r[SW];
      a_d[k] = ai >> SW;
      b_d[k] = bi >> SW;
      s_d[k] = s_q[k-1] | (WIDTH'(r[SW-1:0]) << (SW * k));
    end
`ifdef CLA_OVERFLOW_EN
    // ai/bi/r now hold the top stage; carry into the MSB is recovered as
    // a^b^s of the MSB, then XORed with the top carry-out.
    ovf_d = ai[SW-1] ^ bi[SW-1] ^ r[SW-1] ^ r[SW];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef CLA_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef CLA_OVERFLOW_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
`ifdef CLA_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: self-checking bench for cla_pipe_adder.
// Reference model computes a+b+cin / a-b with plain arithmetic and signed
// range checks; a negedge monitor scoreboards every transferred result.
module tb_cla_pipe_adder #(
  parameter int W = 16,
  parameter int G = 1
);
  localparam int ST = W / (4 * G);
  localparam logic [W-1:0] ALL1 = '1;
  localparam logic [W-1:0] ONE  = 1;
  localparam logic [W-1:0] MAXP = ALL1 >> 1;
  localparam logic [W-1:0] MINN = MAXP + ONE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();
  cla_pipe_adder #(.WIDTH(W), .GPS(G)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  bit           chk_lat = 1'b1;
  bit           stalled = 1'b0;
  bit           done    = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb, input int acc, input bit lat);
    exp_t   r;
    longint sa, sbv, res, hi, lo;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    hi  = (longint'(1) <<< (W - 1)) - 1;
    lo  = -(longint'(1) <<< (W - 1));
    if (sb) begin
      r.s  = a - b;
      r.co = (a >= b);
      res  = sa - sbv;
    end else begin
      {r.co, r.s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      res = sa + sbv + longint'(ci);
    end
    r.ov  = (res > hi) || (res < lo);
    r.acc = acc;
    r.lat = lat;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (stalled) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.sum, prev_sum);
        check("hold_cout", bus.cout, prev_cout);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got sum %0h expected no result", bus.sum);
        end else begin
          e = q.pop_front();
          check("sum", bus.sum, e.s);
          check("cout", bus.cout, e.co);
`ifdef CLA_OVERFLOW_EN
          check("ovf", bus.ovf, e.ov);
`endif
          if (e.lat) check("latency", cyc - e.acc, ST);
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, cyc, chk_lat));
      stalled   = bus.out_valid && !bus.out_ready;
      prev_sum  = bus.sum;
      prev_cout = bus.cout;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    int n;
    bus.in_valid = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
    bus.sub = sb;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb,
                          input logic [W-1:0] xs, input logic xc, input logic xo);
    int n;
    send(a, b, ci, sb);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1", nm);
    end else begin
      check({nm, "_sum"}, bus.sum, xs);
      check({nm, "_cout"}, bus.cout, xc);
`ifdef CLA_OVERFLOW_EN
      check({nm, "_ovf"}, bus.ovf, xo);
`endif
      if (xo === 1'bx) check({nm, "_ovf_x"}, 0, 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Model pins against hand-computed values.
    e = model(ALL1, ONE, 1'b0, 1'b0, 0, 0);
    check("pin_wrap", {e.co, e.ov, e.s}, {1'b1, 1'b0, {W{1'b0}}});
    e = model(W'(5), W'(7), 1'b1, 1'b1, 0, 0);
    check("pin_sub", {e.co, e.ov, e.s}, {1'b0, 1'b0, ALL1 - ONE});
    e = model(MAXP, ONE, 1'b0, 1'b0, 0, 0);
    check("pin_ovf", {e.co, e.ov, e.s}, {1'b0, 1'b1, MINN});

    // 1. reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
`ifdef CLA_OVERFLOW_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 2./3. directed
    directed("wrap", ALL1, ONE, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    directed("sub57", W'(5), W'(7), 1'b1, 1'b1, ALL1 - ONE, 1'b0, 1'b0);
    directed("ovf", MAXP, ONE, 1'b0, 1'b0, MINN, 1'b0, 1'b1);
    directed("subeq", W'(9), W'(9), 1'b0, 1'b1, '0, 1'b1, 1'b0);
    drain();

    // 4. 8 back-to-back random beats
    for (int i = 0; i < 8; i++) send_rand();
    drain();

    // 5. stall from first out_valid for 5 cycles
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
      end
      begin
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!bus.out_valid && n < 50) begin
          n++;
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random bubbles and random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // 6. reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_quiet", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_rand();
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
